// File: rtl/rsa_decrypt_if.sv
// Start/finish handshake bundle for the RSA decryptor.
// The requester uses the master modport and the decryptor uses the slave modport.
interface rsa_decrypt_if #(
  parameter int N_W = 16,
  parameter int D_W = 16
);
  logic           start;
  logic [N_W-1:0] c;
  logic [D_W-1:0] d;
  logic [N_W-1:0] n;
  logic [N_W-1:0] m;
  logic           finish;
  logic           busy;
  logic           err;

  modport master (output start, c, d, n, input  m, finish, busy, err);
  modport slave  (input  start, c, d, n, output m, finish, busy, err);
endinterface

// File: rtl/rsa_decrypt.sv
// Computes m = c^d mod n by left-to-right square-and-multiply over a bit-serial modular multiplier.
// CONST_TIME=1 inserts a dummy multiply on each 0-bit of d, so run time does not depend on the key.
module rsa_decrypt #(
  parameter int N_W        = 16,
  parameter int D_W        = 16,
  parameter int CONST_TIME = 0
) (
  input logic         clk,
  input logic         rst_n,
  rsa_decrypt_if.slave bus
);
  localparam int IW = (D_W > 1) ? $clog2(D_W) : 1;
  localparam int JW = (N_W > 1) ? $clog2(N_W) : 1;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t         state, state_nxt;
  logic [N_W-1:0] c_q, n_q, r, acc, m_q;
  logic [D_W-1:0] d_q;
  logic [IW-1:0]  idx;
  logic [JW-1:0]  jcnt;
  logic           err_q;

  logic [N_W-1:0] mul_b, mm_res, r_fin;
  logic [N_W:0]   t0, t1, t2, t3;
  logic           mm_done, last, dbit, op_bad;

  // One shift-add step: acc = (2*acc + b[j]*r) mod n. Both reductions are needed because acc < n.
  always_comb begin
    mul_b   = (state == MUL) ? c_q : r;
    t0      = {acc, 1'b0};
    t1      = (t0 >= {1'b0, n_q}) ? t0 - {1'b0, n_q} : t0;
    t2      = mul_b[jcnt] ? t1 + {1'b0, r} : t1;
    t3      = (t2 >= {1'b0, n_q}) ? t2 - {1'b0, n_q} : t2;
    mm_res  = t3[N_W-1:0];
    mm_done = (jcnt == '0);
    last    = (idx == '0);
    dbit    = d_q[idx];
    op_bad  = (bus.n < N_W'(2)) || (bus.c >= bus.n);
    r_fin   = (state == MUL && !dbit) ? r : mm_res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = bus.start ? (op_bad ? DONE : SQR) : IDLE;
      SQR: if (mm_done) state_nxt = (dbit || CONST_TIME != 0) ? MUL : (last ? DONE : SQR);
      MUL: if (mm_done) state_nxt = last ? DONE : SQR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q   <= '0;
      d_q   <= '0;
      n_q   <= '0;
      r     <= '0;
      acc   <= '0;
      m_q   <= '0;
      idx   <= '0;
      jcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            c_q  <= bus.c;
            d_q  <= bus.d;
            n_q  <= bus.n;
            r    <= N_W'(1);
            idx  <= IW'(D_W - 1);
            acc  <= '0;
            jcnt <= JW'(N_W - 1);
            if (op_bad) begin
              m_q   <= '0;
              err_q <= 1'b1;
            end
          end
        end
        SQR, MUL: begin
          if (mm_done) begin
            acc  <= '0;
            jcnt <= JW'(N_W - 1);
            r    <= r_fin;
            // Bit index advances on every phase boundary except square -> multiply of the same bit.
            if (state_nxt == DONE) begin
              m_q   <= r_fin;
              err_q <= 1'b0;
            end else if (state_nxt == SQR) begin
              idx <= idx - 1'b1;
            end
          end else begin
            acc  <= mm_res;
            jcnt <= jcnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.finish = (state == DONE);
    bus.busy   = (state == SQR) || (state == MUL);
    bus.err    = (state == DONE) && err_q;
    bus.m      = m_q;
  end
endmodule

// File: tb/tb_rsa_decrypt.sv
// Bench for rsa_decrypt: a leaky and a constant-time instance run side by side against a
// right-to-left modexp model, with a per-instance queue of expected result, error flag and finish cycle.
module tb_rsa_decrypt;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int unsigned ncmp = 0;
  int unsigned nfail = 0;

  typedef struct {
    logic [15:0] m;
    logic        err;
    int unsigned fin;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  rsa_decrypt_if #(.N_W(16), .D_W(16)) if0 ();
  rsa_decrypt_if #(.N_W(16), .D_W(16)) if1 ();

  rsa_decrypt #(.N_W(16), .D_W(16), .CONST_TIME(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  rsa_decrypt #(.N_W(16), .D_W(16), .CONST_TIME(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit bad_ops(input logic [15:0] c, input logic [15:0] n);
    return (n < 16'd2) || (c >= n);
  endfunction

  function automatic logic [15:0] golden(input logic [15:0] c, input logic [15:0] d,
                                         input logic [15:0] n);
    longint unsigned res, b, e;
    if (bad_ops(c, n)) return 16'd0;
    res = 1;
    b   = c;
    e   = d;
    while (e != 0) begin
      if (e[0]) res = (res * b) % n;
      b = (b * b) % n;
      e = e >> 1;
    end
    return 16'(res % n);
  endfunction

  function automatic int unsigned lat(input logic [15:0] c, input logic [15:0] d,
                                      input logic [15:0] n, input bit ct);
    if (bad_ops(c, n)) return 0;
    if (ct) return 16 * 32;
    return 16 * (16 + $countones(d));
  endfunction

  // Called at a negedge; the following posedge is the start edge T0.
  task automatic go(input bit u0, input bit u1, input logic [15:0] c, input logic [15:0] d,
                    input logic [15:0] n);
    exp_t e;
    if0.start = u0; if0.c = c; if0.d = d; if0.n = n;
    if1.start = u1; if1.c = c; if1.d = d; if1.n = n;
    e.m   = golden(c, d, n);
    e.err = bad_ops(c, n);
    if (u0) begin e.fin = cyc + 1 + lat(c, d, n, 1'b0); q0.push_back(e); end
    if (u1) begin e.fin = cyc + 1 + lat(c, d, n, 1'b1); q1.push_back(e); end
    @(posedge clk);
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic pulse_ignored(input logic [15:0] c, input logic [15:0] d, input logic [15:0] n);
    if0.start = 1'b1; if0.c = c; if0.d = d; if0.n = n;
    if1.start = 1'b1; if1.c = c; if1.d = d; if1.n = n;
    @(negedge clk);
    if0.start = 1'b0;
    if1.start = 1'b0;
  endtask

  task automatic drain(input int unsigned budget);
    for (int unsigned k = 0; k < budget && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
    chk("drain_pending", q0.size() + q1.size(), 0);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n && if0.finish) begin
      if (q0.size() == 0) chk("u0_unexpected_finish", if0.finish, 0);
      else begin
        e = q0.pop_front();
        chk("u0_m", if0.m, e.m);
        chk("u0_err", if0.err, e.err);
        chk("u0_finish_cycle", cyc, e.fin);
        chk("u0_busy_at_finish", if0.busy, 0);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && if1.finish) begin
      if (q1.size() == 0) chk("u1_unexpected_finish", if1.finish, 0);
      else begin
        e = q1.pop_front();
        chk("u1_m", if1.m, e.m);
        chk("u1_err", if1.err, e.err);
        chk("u1_finish_cycle", cyc, e.fin);
        chk("u1_busy_at_finish", if1.busy, 0);
      end
    end
  end

  initial begin
    logic [15:0] rc, enc;
    longint unsigned t;
    if0.start = 1'b0; if0.c = '0; if0.d = '0; if0.n = '0;
    if1.start = 1'b0; if1.c = '0; if1.d = '0; if1.n = '0;
    repeat (3) @(negedge clk);
    chk("rst_m", if0.m, 0);
    chk("rst_finish", if0.finish, 0);
    chk("rst_busy", if0.busy, 0);
    chk("rst_err", if0.err, 0);
    chk("rst_m_ct", if1.m, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reference key, with busy sampled mid-run on both instances
    go(1, 1, 16'd1394, 16'd2011, 16'd3127);
    repeat (10) @(negedge clk);
    chk("u0_busy_mid", if0.busy, 1);
    chk("u1_busy_mid", if1.busy, 1);
    drain(1200);

    go(1, 1, 16'd2, 16'd10, 16'd1000);
    drain(1200);

    // Operand edge cases
    go(1, 1, 16'd55, 16'd0, 16'd3127);     drain(1200);
    go(1, 1, 16'd3127, 16'd2011, 16'd3127); drain(1200);
    go(1, 1, 16'd0, 16'd7, 16'd1);          drain(1200);
    go(1, 1, 16'd0, 16'd7, 16'd0);          drain(1200);
    go(1, 1, 16'd0, 16'd5, 16'd3127);       drain(1200);
    go(1, 1, 16'd0, 16'd0, 16'd3127);       drain(1200);

    // Round trip through the public exponent e=3
    t = (64'd89 * 64'd89 * 64'd89) % 64'd3127;
    enc = 16'(t);
    go(1, 1, enc, 16'd2011, 16'd3127);
    drain(1200);

    // A start while busy must not disturb the running operation
    go(1, 1, 16'd1394, 16'd2011, 16'd3127);
    repeat (50) @(negedge clk);
    pulse_ignored(16'd7, 16'd3, 16'd100);
    drain(1200);

    // Back-to-back request issued in the finish cycle
    go(1, 0, 16'd1394, 16'd2011, 16'd3127);
    for (int unsigned k = 0; k < 1000 && !if0.finish; k++) @(negedge clk);
    chk("u0_finish_seen", if0.finish, 1);
    go(1, 0, 16'd2, 16'd10, 16'd1000);
    drain(1200);

    for (int unsigned k = 0; k < 6; k++) begin
      rc = 16'($urandom_range(0, 3126));
      go(1, 1, rc, 16'd2011, 16'd3127);
      drain(1200);
    end

    // Reset mid-operation aborts without a finish pulse
    go(1, 1, 16'd1394, 16'd2011, 16'd3127);
    repeat (199) @(negedge clk);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_m", if0.m, 0);
    chk("abort_busy", if0.busy, 0);
    chk("abort_finish", if0.finish, 0);
    chk("abort_busy_ct", if1.busy, 0);
    chk("abort_m_ct", if1.m, 0);
    repeat (600) @(negedge clk);
    go(1, 1, 16'd1394, 16'd2011, 16'd3127);
    drain(1200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
